bank_cmd_issuer: RTL and testbench
==================================

# bank_cmd_issuer

Per-bank DRAM command initiator: accepts read/write requests from the controller front end and emits ACT/RD/WR/PR/REF command pulses that obey bank timing (tRCD, tRAS, tRP, tRTP, tWR, tRFC, burst spacing), plus periodic refresh. It is the host-side counterpart of the per-bank timing state machine in the memory model, and drives that block's ACT/RD/WR/PR/REF inputs directly. Policy is open-page.

## Interface
- T_RCD, 17, ACT to first RD/WR (cycles)
- T_RAS, 32, ACT to PR minimum
- T_RP, 17, PR to next ACT/REF
- T_RTP, 7, RD to PR minimum
- T_WR, 14, WR to PR minimum
- T_RFC, 34, REF to next ACT/REF
- T_REFI, 7800, refresh interval
- BL, 8, minimum spacing between column commands
- ROWW, 14, row address width
- COLW, 10, column address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present; row/col/write held stable until accepted
- req_write  in  1  1 = write, 0 = read
- req_row  in  ROWW  row address
- req_col  in  COLW  column address
- req_ready  out  1  combinational; transfer on the edge where req_valid && req_ready
- ACT, RD, WR, PR, REF  out  1 each  registered one-cycle command pulses, mutually exclusive
- cmd_row  out  ROWW  row for ACT (registered)
- cmd_col  out  COLW  column for RD/WR (registered)
- open_row_valid  out  1  a row is open
- ref_pending  out  1  refresh due, not yet issued

## Operation
- States: IDLE (bank closed), ACTIVATING, OPEN, PRECHARGING, REFRESHING.
- IDLE: ref_pending wins → REF, go REFRESHING; else req_valid → ACT with req_row, latch open_row, go ACTIVATING.
- ACTIVATING: after T_RCD → OPEN.
- OPEN: req_ready = req_valid && row hit && column spacing elapsed && !ref_pending. On transfer: RD or WR with req_col.
- OPEN with row miss or ref_pending: PR once tRAS, tRTP (after RD), tWR (after WR) and burst spacing all satisfied; clear open_row_valid; go PRECHARGING.
- PRECHARGING: after T_RP → IDLE. REFRESHING: after T_RFC → IDLE.
- Refresh: free-running interval counter reloads T_REFI; at expiry set ref_pending; cleared on REF issue. An expiry while already pending is not accumulated.
- req_ready is 0 in every state except OPEN.
- Reset: state IDLE, all command outputs 0, cmd_row/cmd_col 0, open_row_valid 0, ref_pending 0, all timing counters 0, interval counter T_REFI. Reset in any state, including mid-burst or mid-tRCD, takes effect at the next edge with no further commands.

## Timing
- Decision in cycle n from registered state + current request; command pulse in cycle n+1.
- Spacing between command pulses is exact when requests are waiting: ACT→RD/WR = T_RCD; RD/WR→RD/WR = BL; ACT→PR ≥ T_RAS; RD→PR ≥ T_RTP; WR→PR ≥ T_WR; PR→ACT/REF = T_RP; REF→ACT/REF = T_RFC.
- Precharge issues at the cycle the last pending constraint expires, i.e. max of all applicable limits.
- Counters are 8-bit and saturate at 0. The interval counter is 16-bit.
- Priority in every decision cycle: refresh, then row-miss precharge, then column command.

## Structure
- Package bank_cmd_pkg: state enum, command encoding enum, default timing constants.
- One sub-module, timing_down_counter: loadable 8-bit down counter with a zero flag. It is instantiated once per constraint (rcd, ras, rp, rtp, wr, rfc, col).

## Test plan
- Read after reset at cycle 0, row 5 col 3: ACT high cycle 1 with cmd_row=5; req_ready high cycle 17; RD high cycle 18 with cmd_col=3.
- Two hit reads held back-to-back: RD pulses exactly 8 cycles apart; req_ready low in between.
- ACT row 5, WR at +17, then request row 9: PR at ACT+32 (tRAS dominates WR+14); ACT row 9 at PR+17.
- T_REFI=100 with bank open and continuous hits: ref_pending rises; column commands stop; PR, then REF 17 cycles later; ACT no earlier than REF+34.
- Refresh expiry in the same cycle as req_valid in IDLE: REF issued, no ACT; ACT follows at REF+34.
- rst asserted in ACTIVATING, 5 cycles after ACT: next cycle all commands 0, open_row_valid 0, req_ready 0; a new request restarts with a fresh ACT.

Source files
------------

// File: rtl/bank_cmd_issuer_pkg.sv
// Shared types and default DRAM timing for the per-bank command issuer.
// The state and command enums and the counter preload helper live here.
package bank_cmd_pkg;

  localparam int unsigned DEF_T_RCD  = 17;
  localparam int unsigned DEF_T_RAS  = 32;
  localparam int unsigned DEF_T_RP   = 17;
  localparam int unsigned DEF_T_RTP  = 7;
  localparam int unsigned DEF_T_WR   = 14;
  localparam int unsigned DEF_T_RFC  = 34;
  localparam int unsigned DEF_T_REFI = 7800;
  localparam int unsigned DEF_BL     = 8;
  localparam int          DEF_ROWW   = 14;
  localparam int          DEF_COLW   = 10;

  localparam int CNT_W  = 8;
  localparam int REFI_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_OPEN,
    ST_PRECHARGING,
    ST_REFRESHING
  } bank_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PR,
    CMD_REF
  } bank_cmd_e;

  // A counter loaded with t-1 at the deciding edge reads zero in the cycle
  // whose decision lands the next command exactly t cycles after this one.
  function automatic logic [CNT_W-1:0] t_load(input int unsigned t);
    if (t == 0) return '0;
    if (t - 1 > (1 << CNT_W) - 1) return '1;
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/bank_cmd_issuer_if.sv
// Request and command bus between the controller front end, the issuer and
// the bank timing model.
interface bank_cmd_issuer_if
  import bank_cmd_pkg::*;
#(
  parameter int ROWW = DEF_ROWW,
  parameter int COLW = DEF_COLW
);
  logic            req_valid;
  logic            req_write;
  logic [ROWW-1:0] req_row;
  logic [COLW-1:0] req_col;
  logic            req_ready;

  logic            ACT;
  logic            RD;
  logic            WR;
  logic            PR;
  logic            REF;
  logic [ROWW-1:0] cmd_row;
  logic [COLW-1:0] cmd_col;
  logic            open_row_valid;
  logic            ref_pending;

  modport master (
    output req_valid, req_write, req_row, req_col,
    input  req_ready, ACT, RD, WR, PR, REF, cmd_row, cmd_col,
    input  open_row_valid, ref_pending
  );

  modport slave (
    input  req_valid, req_write, req_row, req_col,
    output req_ready, ACT, RD, WR, PR, REF, cmd_row, cmd_col,
    output open_row_valid, ref_pending
  );
endinterface

// File: rtl/bank_cmd_issuer_timing_down_counter.sv
// Loadable down counter that saturates at zero; one instance tracks one
// bank timing constraint.
module timing_down_counter
  import bank_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o,
  output logic             near_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  // Set one cycle before zero so a state can move on in time for the next decision.
  assign near_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/bank_cmd_issuer.sv
// Open-page per-bank DRAM command issuer: turns front-end requests into
// ACT/RD/WR/PR/REF pulses that respect bank timing and periodic refresh.
module bank_cmd_issuer
  import bank_cmd_pkg::*;
#(
  parameter int unsigned T_RCD  = DEF_T_RCD,
  parameter int unsigned T_RAS  = DEF_T_RAS,
  parameter int unsigned T_RP   = DEF_T_RP,
  parameter int unsigned T_RTP  = DEF_T_RTP,
  parameter int unsigned T_WR   = DEF_T_WR,
  parameter int unsigned T_RFC  = DEF_T_RFC,
  parameter int unsigned T_REFI = DEF_T_REFI,
  parameter int unsigned BL     = DEF_BL,
  parameter int          ROWW   = DEF_ROWW,
  parameter int          COLW   = DEF_COLW
) (
  input logic               clk,
  input logic               rst,
  bank_cmd_issuer_if.slave  bus
);
  localparam int TC_RCD = 0;
  localparam int TC_RAS = 1;
  localparam int TC_RP  = 2;
  localparam int TC_RTP = 3;
  localparam int TC_WR  = 4;
  localparam int TC_RFC = 5;
  localparam int TC_COL = 6;
  localparam int TC_N   = 7;

  localparam logic [CNT_W-1:0] TC_VAL [TC_N] = '{
    t_load(T_RCD), t_load(T_RAS), t_load(T_RP), t_load(T_RTP),
    t_load(T_WR), t_load(T_RFC), t_load(BL)
  };

  bank_state_e     state_q, state_d;
  bank_cmd_e       issue;
  logic            act_q, rd_q, wr_q, pr_q, ref_q;
  logic [ROWW-1:0] cmd_row_q, cmd_row_d;
  logic [ROWW-1:0] open_row_q, open_row_d;
  logic [COLW-1:0] cmd_col_q, cmd_col_d;
  logic            open_row_valid_q, open_row_valid_d;
  logic            ref_pending_q, ref_pending_d;
  logic [REFI_W-1:0] refi_q, refi_d;
  logic            refi_expire;
  logic            req_ready;
  logic            row_hit;
  logic            pr_ok;

  logic [TC_N-1:0] tc_load, tc_zero, tc_near;
  logic            unused_near;

  for (genvar i = 0; i < TC_N; i++) begin : g_tc
    timing_down_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tc_load[i]),
      .load_val_i (TC_VAL[i]),
      .zero_o     (tc_zero[i]),
      .near_o     (tc_near[i])
    );
  end

  assign unused_near = ^{tc_near[TC_RAS], tc_near[TC_RTP], tc_near[TC_WR], tc_near[TC_COL]};

  assign row_hit = (bus.req_row == open_row_q);
  assign pr_ok   = tc_zero[TC_RAS] & tc_zero[TC_RTP] & tc_zero[TC_WR] & tc_zero[TC_COL];

  // Decision stage: priority is refresh, then row-miss precharge, then column command.
  always_comb begin
    state_d          = state_q;
    issue            = CMD_NONE;
    req_ready        = 1'b0;
    open_row_d       = open_row_q;
    open_row_valid_d = open_row_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tc_zero[TC_RP] && tc_zero[TC_RFC]) begin
          if (ref_pending_q) begin
            issue   = CMD_REF;
            state_d = ST_REFRESHING;
          end else if (bus.req_valid) begin
            issue            = CMD_ACT;
            open_row_d       = bus.req_row;
            open_row_valid_d = 1'b1;
            state_d          = ST_ACTIVATING;
          end
        end
      end
      ST_ACTIVATING: begin
        if (tc_near[TC_RCD]) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (ref_pending_q || (bus.req_valid && !row_hit)) begin
          if (pr_ok) begin
            issue            = CMD_PR;
            open_row_valid_d = 1'b0;
            state_d          = ST_PRECHARGING;
          end
        end else if (bus.req_valid && tc_zero[TC_COL] && tc_zero[TC_RCD]) begin
          req_ready = 1'b1;
          issue     = bus.req_write ? CMD_WR : CMD_RD;
        end
      end
      ST_PRECHARGING: begin
        if (tc_near[TC_RP]) state_d = ST_IDLE;
      end
      ST_REFRESHING: begin
        if (tc_near[TC_RFC]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tc_load = '0;
    unique case (issue)
      CMD_ACT: begin tc_load[TC_RCD] = 1'b1; tc_load[TC_RAS] = 1'b1; end
      CMD_RD:  begin tc_load[TC_COL] = 1'b1; tc_load[TC_RTP] = 1'b1; end
      CMD_WR:  begin tc_load[TC_COL] = 1'b1; tc_load[TC_WR]  = 1'b1; end
      CMD_PR:  tc_load[TC_RP]  = 1'b1;
      CMD_REF: tc_load[TC_RFC] = 1'b1;
      default: tc_load = '0;
    endcase
  end

  always_comb begin
    cmd_row_d   = (issue == CMD_ACT) ? bus.req_row : cmd_row_q;
    cmd_col_d   = (issue == CMD_RD || issue == CMD_WR) ? bus.req_col : cmd_col_q;
    refi_expire = (refi_q <= REFI_W'(1));
    refi_d      = refi_expire ? REFI_W'(T_REFI) : refi_q - REFI_W'(1);
    // A second expiry while still pending is dropped, not counted.
    ref_pending_d = (ref_pending_q && (issue != CMD_REF)) || refi_expire;
  end

  // Command stage: one-cycle registered pulses follow the decision cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      act_q            <= 1'b0;
      rd_q             <= 1'b0;
      wr_q             <= 1'b0;
      pr_q             <= 1'b0;
      ref_q            <= 1'b0;
      cmd_row_q        <= '0;
      cmd_col_q        <= '0;
      open_row_valid_q <= 1'b0;
      ref_pending_q    <= 1'b0;
      refi_q           <= REFI_W'(T_REFI);
    end else begin
      state_q          <= state_d;
      act_q            <= (issue == CMD_ACT);
      rd_q             <= (issue == CMD_RD);
      wr_q             <= (issue == CMD_WR);
      pr_q             <= (issue == CMD_PR);
      ref_q            <= (issue == CMD_REF);
      cmd_row_q        <= cmd_row_d;
      cmd_col_q        <= cmd_col_d;
      open_row_valid_q <= open_row_valid_d;
      ref_pending_q    <= ref_pending_d;
      refi_q           <= refi_d;
    end
  end

  always_ff @(posedge clk) begin
    open_row_q <= open_row_d;
  end

  assign bus.req_ready      = req_ready;
  assign bus.ACT            = act_q;
  assign bus.RD             = rd_q;
  assign bus.WR             = wr_q;
  assign bus.PR             = pr_q;
  assign bus.REF            = ref_q;
  assign bus.cmd_row        = cmd_row_q;
  assign bus.cmd_col        = cmd_col_q;
  assign bus.open_row_valid = open_row_valid_q;
  assign bus.ref_pending    = ref_pending_q;

endmodule

// File: tb/tb_bank_cmd_issuer.sv
// Bench for bank_cmd_issuer: request table plus refresh/reset sequences,
// with every command pulse checked against a queue of expected commands.
module tb_bank_cmd_issuer;
  import bank_cmd_pkg::*;

  localparam int ROWW = DEF_ROWW;
  localparam int COLW = DEF_COLW;
  localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PR = 4, K_REF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_cmd_issuer_if #(.ROWW(ROWW), .COLW(COLW)) bif ();

  bank_cmd_issuer #(.T_REFI(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    int kind;
    int addr;
    int at;
  } exp_t;

  typedef struct {
    bit w;
    int row;
    int col;
    int exp_ready;
    int exp_pr;
    int exp_act;
    int exp_col;
  } vec_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic push(input int k, input int a, input int t);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.at   = t;
    sbq.push_back(e);
  endtask

  // Every command pulse is popped against the expected queue.
  always @(negedge clk) begin
    int   n;
    int   kind;
    int   addr;
    exp_t e;
    if (!rst) begin
      n = int'(bif.ACT) + int'(bif.RD) + int'(bif.WR) + int'(bif.PR) + int'(bif.REF);
      if (n > 1) check("cmd_onehot", n, 1);
      if (n != 0) begin
        kind = bif.ACT ? K_ACT : bif.RD ? K_RD : bif.WR ? K_WR : bif.PR ? K_PR : K_REF;
        addr = (kind == K_ACT) ? int'(bif.cmd_row) :
               (kind == K_RD || kind == K_WR) ? int'(bif.cmd_col) : 0;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd: got kind=%0d addr=%0d cycle=%0d, expected no command",
                   kind, addr, cyc - base);
        end else begin
          e = sbq.pop_front();
          if (kind != e.kind || addr != e.addr || (cyc - base) != e.at) begin
            failures++;
            $display("FAIL cmd_seq: got kind=%0d addr=%0d cycle=%0d, expected kind=%0d addr=%0d cycle=%0d",
                     kind, addr, cyc - base, e.kind, e.addr, e.at);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic wait_rel(input int r);
    while ((cyc - base) < r) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input bit w, input int row, input int col, input int exp_ready);
    bit got = 0;
    int ready_at = -1;
    bif.req_valid = 1'b1;
    bif.req_write = w;
    bif.req_row   = ROWW'(row);
    bif.req_col   = COLW'(col);
    for (int n = 0; n < 300; n++) begin
      #1;
      if (bif.req_ready) begin
        got      = 1;
        ready_at = cyc - base;
      end
      @(negedge clk);
      if (got) break;
    end
    if (!got) check("req_accept_timeout", 0, 1);
    else if (exp_ready >= 0) check("ready_cycle", ready_at, exp_ready);
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && sbq.size() != 0; n++) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{0, 5, 3, 17, -1,  1, 18};
    tbl[1] = '{1, 5, 7, 25, -1, -1, 26};
    tbl[2] = '{0, 5, 1, 33, -1, -1, 34};
    tbl[3] = '{1, 9, 2, 75, 42, 59, 76};
    tbl[4] = '{0, 9, 4, 83, -1, -1, 84};

    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_row   = '0;
    bif.req_col   = '0;
    @(negedge clk);
    do_reset();

    check("rst_cmds", int'({bif.ACT, bif.RD, bif.WR, bif.PR, bif.REF}), 0);
    check("rst_cmd_row", int'(bif.cmd_row), 0);
    check("rst_cmd_col", int'(bif.cmd_col), 0);
    check("rst_open_row_valid", int'(bif.open_row_valid), 0);
    check("rst_ref_pending", int'(bif.ref_pending), 0);
    #1 check("rst_req_ready", int'(bif.req_ready), 0);

    // Open-page request table: hits, a write, a row miss, requests held back to back.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].exp_pr >= 0) push(K_PR, 0, tbl[i].exp_pr);
      if (tbl[i].exp_act >= 0) push(K_ACT, tbl[i].row, tbl[i].exp_act);
      push(tbl[i].w ? K_WR : K_RD, tbl[i].col, tbl[i].exp_col);
      send(tbl[i].w, tbl[i].row, tbl[i].col, tbl[i].exp_ready);
    end
    bif.req_valid = 1'b0;
    drain(20);
    check("tbl_open_row_valid", int'(bif.open_row_valid), 1);
    #1 check("tbl_idle_ready", int'(bif.req_ready), 0);
    @(negedge clk);

    // Refresh comes due while the bank is open and hits keep arriving.
    do_reset();
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          if (k == 0) push(K_ACT, 5, 1);
          if (k < 11) begin
            push(K_RD, k, 18 + 8 * k);
          end else begin
            push(K_PR, 0, 106);
            push(K_REF, 0, 123);
            push(K_ACT, 5, 157);
            push(K_RD, 11, 174);
          end
          send(0, 5, k, (k < 11) ? 17 + 8 * k : 173);
        end
      end
      begin
        wait_rel(99);
        check("refp_before_expiry", int'(bif.ref_pending), 0);
        wait_rel(100);
        check("refp_at_expiry", int'(bif.ref_pending), 1);
        wait_rel(105);
        #1 check("ready_blocked_by_refresh", int'(bif.req_ready), 0);
        wait_rel(110);
        check("precharging_row_closed", int'(bif.open_row_valid), 0);
        wait_rel(122);
        check("refp_until_ref", int'(bif.ref_pending), 1);
        wait_rel(124);
        check("refp_cleared_by_ref", int'(bif.ref_pending), 0);
      end
    join
    bif.req_valid = 1'b0;
    drain(20);
    @(negedge clk);

    // Refresh becomes due in IDLE in the same cycle a request appears.
    do_reset();
    for (int n = 0; n < 200 && !bif.ref_pending; n++) @(negedge clk);
    check("refp_rise_cycle", cyc - base, 100);
    push(K_REF, 0, 101);
    push(K_ACT, 7, 135);
    push(K_RD, 2, 152);
    send(0, 7, 2, 151);
    bif.req_valid = 1'b0;
    drain(20);
    @(negedge clk);

    // Reset in the middle of tRCD, then a fresh activation.
    do_reset();
    push(K_ACT, 5, 1);
    bif.req_valid = 1'b1;
    bif.req_write = 1'b0;
    bif.req_row   = ROWW'(5);
    bif.req_col   = COLW'(3);
    wait_rel(6);
    check("activating_row_open", int'(bif.open_row_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrcd_rst_cmds", int'({bif.ACT, bif.RD, bif.WR, bif.PR, bif.REF}), 0);
    check("midrcd_rst_open_row_valid", int'(bif.open_row_valid), 0);
    #1 check("midrcd_rst_req_ready", int'(bif.req_ready), 0);
    check("midrcd_sb_consumed", sbq.size(), 0);
    rst  = 1'b0;
    base = cyc;
    push(K_ACT, 5, 1);
    push(K_RD, 3, 18);
    send(0, 5, 3, 17);
    bif.req_valid = 1'b0;
    drain(20);

    repeat (3) @(negedge clk);
    check("final_queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
